tuner_sweep_ctrl: RTL and testbench

Search-channel sweep controller that sits directly upstream of the tuner transaction adapter. On a start request it steps a ring tune code from a start value to an end value. For each code it issues one transaction on the tuner transaction interface, collects the returned power, and tracks the code with maximum power. Results go to the search FSM, plus a per-sample debug stream.

---
 rtl/tuner_phy_pkg.sv | 26 ++
 rtl/tuner_txn_if.sv | 25 ++
 rtl/tuner_peak_track.sv | 34 +++
 rtl/tuner_sweep_ctrl.sv | 178 +++++++++++++++++
 tb/tb_tuner_sweep_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tuner_phy_pkg.sv
// Shared types for the tuner sweep controller slice.
// Struct field widths follow the default tune-code / power widths.
package tuner_phy_pkg;

    localparam int unsigned SWEEP_DAC_WIDTH = 8;
    localparam int unsigned SWEEP_ADC_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        UPDATE,
        DONE
    } sweep_state_e;

    typedef struct packed {
        logic [SWEEP_DAC_WIDTH-1:0] code_start;
        logic [SWEEP_DAC_WIDTH-1:0] code_end;
        logic [SWEEP_DAC_WIDTH-1:0] code_step;
    } sweep_cfg_t;

    typedef struct packed {
        logic [SWEEP_DAC_WIDTH-1:0] code;
        logic [SWEEP_ADC_WIDTH-1:0] power;
    } sweep_result_t;

endpackage

// File: rtl/tuner_txn_if.sv
// Tuner transaction channel between the sweep controller (ctrl) and the
// tuner transaction adapter. A transaction completes when val && rdy.
interface tuner_txn_if #(
    parameter int unsigned DAC_WIDTH = tuner_phy_pkg::SWEEP_DAC_WIDTH,
    parameter int unsigned ADC_WIDTH = tuner_phy_pkg::SWEEP_ADC_WIDTH
);
    logic                 val;
    logic [DAC_WIDTH-1:0] tune_code;
    logic                 rdy;
    logic [ADC_WIDTH-1:0] meas_power;

    modport ctrl (
        output val,
        output tune_code,
        input  rdy,
        input  meas_power
    );

    modport adapter (
        input  val,
        input  tune_code,
        output rdy,
        output meas_power
    );
endinterface

// File: rtl/tuner_peak_track.sv
// Registered maximum tracker. A sample replaces the stored peak only when
// no peak is held yet or its power is strictly greater, so ties keep the
// earlier sample. Clear drops the valid flag but leaves the last peak
// visible until the first new sample arrives.
module tuner_peak_track #(
    parameter int unsigned DAC_WIDTH = 8,
    parameter int unsigned ADC_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_samp_val,
    input  logic [DAC_WIDTH-1:0] i_samp_code,
    input  logic [ADC_WIDTH-1:0] i_samp_power,
    output logic [DAC_WIDTH-1:0] o_peak_code,
    output logic [ADC_WIDTH-1:0] o_peak_power
);
    logic peak_valid_q;

    // Peak register: clear on new sweep, load on first or strictly larger sample.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            peak_valid_q <= 1'b0;
            o_peak_code  <= '0;
            o_peak_power <= '0;
        end else if (i_clear) begin
            peak_valid_q <= 1'b0;
        end else if (i_samp_val && (!peak_valid_q || (i_samp_power > o_peak_power))) begin
            peak_valid_q <= 1'b1;
            o_peak_code  <= i_samp_code;
            o_peak_power <= i_samp_power;
        end
    end
endmodule

// File: rtl/tuner_sweep_ctrl.sv
// Search-channel sweep controller: steps a tune code from start to end,
// issues one tuner transaction per code, reports each sample and tracks
// the code of maximum power.
// Optional build macro TUNER_SWEEP_AVG_EN: issue 2^AVG_LOG2 transactions
// per code and report the averaged power.
module tuner_sweep_ctrl
    import tuner_phy_pkg::*;
#(
    parameter int unsigned DAC_WIDTH = SWEEP_DAC_WIDTH,
    parameter int unsigned ADC_WIDTH = SWEEP_ADC_WIDTH,
    parameter int unsigned AVG_LOG2  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [DAC_WIDTH-1:0] i_code_start,
    input  logic [DAC_WIDTH-1:0] i_code_end,
    input  logic [DAC_WIDTH-1:0] i_code_step,
    tuner_txn_if.ctrl            txn_if,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_aborted,
    output logic [DAC_WIDTH-1:0] o_peak_code,
    output logic [ADC_WIDTH-1:0] o_peak_power,
    output logic                 o_samp_val,
    output logic [DAC_WIDTH-1:0] o_samp_code,
    output logic [ADC_WIDTH-1:0] o_samp_power
);
    sweep_state_e         state_q, state_d;
    sweep_cfg_t           cfg_in;
    sweep_result_t        samp;
    logic [DAC_WIDTH-1:0] cur_q, end_q, step_q;
    logic [DAC_WIDTH:0]   next_code;
    logic                 abort_pend_q;
    logic                 abort_now;
    logic                 last_code;
    logic                 fire;
    logic                 start_ok;
    logic                 samp_last;
    logic [ADC_WIDTH-1:0] code_power;

`ifdef TUNER_SWEEP_AVG_EN
    localparam int unsigned CNT_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned SAMPLES = 1 << AVG_LOG2;

    logic [ADC_WIDTH+AVG_LOG2-1:0] acc_q;
    logic [CNT_W-1:0]              samp_cnt_q;

    assign samp_last  = (samp_cnt_q == CNT_W'(SAMPLES - 1));
    assign code_power = ADC_WIDTH'(acc_q >> AVG_LOG2);
`else
    logic [ADC_WIDTH-1:0] meas_q;

    assign samp_last  = 1'b1;
    assign code_power = meas_q;
`endif

    // Step 0 behaves as 1 so a sweep always makes progress.
    assign cfg_in.code_start = i_code_start;
    assign cfg_in.code_end   = i_code_end;
    assign cfg_in.code_step  = (i_code_step == '0) ? DAC_WIDTH'(1) : i_code_step;

    assign start_ok  = (state_q == IDLE) && i_start;
    assign fire      = txn_if.val && txn_if.rdy;
    assign abort_now = abort_pend_q || i_abort;

    // One extra bit so a step past the top code ends the sweep instead of wrapping.
    assign next_code = {1'b0, cur_q} + {1'b0, step_q};
    assign last_code = abort_now || (cur_q >= end_q) || (next_code > {1'b0, end_q});

    assign txn_if.tune_code = cur_q;

    assign samp.code    = cur_q;
    assign samp.power   = code_power;
    assign o_samp_code  = samp.code;
    assign o_samp_power = samp.power;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode and per-state handshake/status outputs.
    always_comb begin
        state_d    = state_q;
        txn_if.val = 1'b0;
        o_busy     = 1'b1;
        o_done     = 1'b0;
        o_samp_val = 1'b0;
        case (state_q)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) state_d = ISSUE;
            end
            ISSUE: begin
                txn_if.val = 1'b1;
                if (fire && samp_last) state_d = UPDATE;
            end
            UPDATE: begin
                o_samp_val = 1'b1;
                state_d    = last_code ? DONE : ISSUE;
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sweep datapath: config capture, code stepping, abort latch, measurement capture.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cur_q        <= '0;
            end_q        <= '0;
            step_q       <= '0;
            abort_pend_q <= 1'b0;
            o_aborted    <= 1'b0;
`ifdef TUNER_SWEEP_AVG_EN
            acc_q        <= '0;
            samp_cnt_q   <= '0;
`else
            meas_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        cur_q        <= cfg_in.code_start;
                        end_q        <= cfg_in.code_end;
                        step_q       <= cfg_in.code_step;
                        abort_pend_q <= 1'b0;
                        o_aborted    <= 1'b0;
                    end
                end
                ISSUE: begin
                    abort_pend_q <= abort_pend_q || i_abort;
                    if (fire) begin
`ifdef TUNER_SWEEP_AVG_EN
                        acc_q      <= acc_q + (ADC_WIDTH + AVG_LOG2)'(txn_if.meas_power);
                        samp_cnt_q <= samp_last ? '0 : samp_cnt_q + 1'b1;
`else
                        meas_q     <= txn_if.meas_power;
`endif
                    end
                end
                UPDATE: begin
                    abort_pend_q <= abort_now;
`ifdef TUNER_SWEEP_AVG_EN
                    acc_q        <= '0;
`endif
                    if (last_code) o_aborted <= abort_now;
                    else           cur_q     <= next_code[DAC_WIDTH-1:0];
                end
                DONE: begin
                    abort_pend_q <= abort_pend_q || i_abort;
                end
                default: ;
            endcase
        end
    end

    tuner_peak_track #(
        .DAC_WIDTH (DAC_WIDTH),
        .ADC_WIDTH (ADC_WIDTH)
    ) u_peak (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (start_ok),
        .i_samp_val   (o_samp_val),
        .i_samp_code  (cur_q),
        .i_samp_power (code_power),
        .o_peak_code  (o_peak_code),
        .o_peak_power (o_peak_power)
    );
endmodule

// File: tb/tb_tuner_sweep_ctrl.sv
// Self-checking bench for tuner_sweep_ctrl: a behavioural adapter answers
// transactions with a table-driven power, and a list-based sweep model
// predicts the issued codes, per-code samples, peak and abort status.
`timescale 1ns/1ps
module tb_tuner_sweep_ctrl;
    localparam int DW = 8;
    localparam int AW = 8;
`ifdef TUNER_SWEEP_AVG_EN
    localparam int SHIFT = 2;
`else
    localparam int SHIFT = 0;
`endif
    localparam int S = 1 << SHIFT;

    logic          clk, rst, i_start, i_abort;
    logic [DW-1:0] i_code_start, i_code_end, i_code_step;
    logic          o_busy, o_done, o_aborted, o_samp_val;
    logic [DW-1:0] o_peak_code, o_samp_code;
    logic [AW-1:0] o_peak_power, o_samp_power;

    tuner_txn_if #(.DAC_WIDTH(DW), .ADC_WIDTH(AW)) txn ();

    tuner_sweep_ctrl #(.DAC_WIDTH(DW), .ADC_WIDTH(AW), .AVG_LOG2(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_abort(i_abort),
        .i_code_start(i_code_start), .i_code_end(i_code_end), .i_code_step(i_code_step),
        .txn_if(txn), .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted),
        .o_peak_code(o_peak_code), .o_peak_power(o_peak_power), .o_samp_val(o_samp_val),
        .o_samp_code(o_samp_code), .o_samp_power(o_samp_power)
    );

    always #5 clk = ~clk;

    int checks, errors;
    int lat, mode, cyc, fire_total, waitc;
    int done_cnt, done_cyc, last_samp_cyc, hold_err;
    logic done_abort, busy_after_done, prev_val, prev_fire, prev_done;
    logic [DW-1:0] prev_code, first_code;
    logic first_val;
    logic [7:0] rtab [256];
    logic [7:0] obs_fire[$], obs_code[$], obs_pow[$];
    logic [7:0] exp_fire[$], exp_code[$], exp_pow[$];
    logic [7:0] exp_pk_code, exp_pk_pow;
    logic exp_ab;

    // Power returned for a given code and sample index within that code.
    function automatic logic [7:0] pw(int m, int code, int idx);
        int d;
        case (m)
            0: begin
                d = (code > 12) ? code - 12 : 12 - code;
                return (d >= 10) ? 8'd0 : 8'(100 - 10 * d);
            end
            1: return 8'd50;
            2: return rtab[code];
            default: return 8'(10 * (idx + 1));
        endcase
    endfunction

    // Sweep reference: list of codes by plain integer stepping, abort truncation, first-max peak.
    function automatic void model(int s, int e, int st, int ab);
        int c, stp, sum, best;
        logic [7:0] nat[$];
        exp_fire.delete(); exp_code.delete(); exp_pow.delete();
        stp = (st == 0) ? 1 : st;
        c = s;
        while (1) begin
            nat.push_back(8'(c));
            if (c >= e || c + stp > e) break;
            c += stp;
        end
        exp_ab = (ab >= 0) && (ab < nat.size());
        best = -1;
        foreach (nat[k]) begin
            if (exp_ab && k > ab) break;
            sum = 0;
            for (int i = 0; i < S; i++) begin
                sum += pw(mode, nat[k], i);
                exp_fire.push_back(nat[k]);
            end
            exp_code.push_back(nat[k]);
            exp_pow.push_back(8'(sum >> SHIFT));
            if ((sum >> SHIFT) > best) begin
                best = sum >> SHIFT;
                exp_pk_code = nat[k];
                exp_pk_pow = 8'(best);
            end
        end
    endfunction

    // Index of first difference between two lists, -1 when identical.
    function automatic int q_diff(input logic [7:0] a[$], input logic [7:0] b[$]);
        if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
        foreach (a[i]) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    // Adapter: raise rdy after lat cycles of val, drop it after each completed transaction.
    always begin
        @(posedge clk); #1;
        if (rst) begin
            txn.rdy = 1'b0; waitc = 0;
        end else begin
            if (prev_fire) begin txn.rdy = 1'b0; waitc = 0; end
            if (txn.val && !txn.rdy) begin
                if (waitc >= lat) begin
                    txn.rdy = 1'b1;
                    txn.meas_power = pw(mode, txn.tune_code, fire_total % S);
                end else waitc++;
            end
        end
    end

    // Monitor: sampled mid-cycle, records fires, samples, done pulses, hold violations.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_val = 1'b0; prev_fire = 1'b0; prev_done = 1'b0;
        end else begin
            if (prev_val && !prev_fire && (!txn.val || txn.tune_code !== prev_code)) hold_err++;
            if (prev_done) busy_after_done = o_busy;
            if (txn.val && txn.rdy) begin obs_fire.push_back(txn.tune_code); fire_total++; end
            if (o_samp_val) begin
                obs_code.push_back(o_samp_code); obs_pow.push_back(o_samp_power); last_samp_cyc = cyc;
            end
            if (o_done) begin done_cnt++; done_cyc = cyc; done_abort = o_aborted; end
            prev_val = txn.val; prev_fire = txn.val && txn.rdy;
            prev_code = txn.tune_code; prev_done = o_done;
        end
    end

    // Runs one sweep and gathers observations; ab>=0 aborts while code #ab is stalled.
    task automatic run_sweep(input int s, input int e, input int st, input int l,
                             input int m, input int ab, input bit ns);
        int waited, vwait;
        bit sent;
        obs_fire.delete(); obs_code.delete(); obs_pow.delete();
        done_cnt = 0; hold_err = 0; fire_total = 0; busy_after_done = 1'b1;
        lat = l; mode = m; sent = 0; vwait = 0; waited = 0;
        model(s, e, st, ab);
        @(posedge clk); #1;
        i_code_start = 8'(s); i_code_end = 8'(e); i_code_step = 8'(st); i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(negedge clk);
        first_val = txn.val; first_code = txn.tune_code;
        while (done_cnt == 0 && waited < 2000) begin
            @(posedge clk); #1;
            i_start = 1'b0; i_abort = 1'b0;
            if (ns && waited == 3) begin
                i_start = 1'b1; i_code_start = 8'(s + 1); i_code_end = 8'(e + 7); i_code_step = 8'd1;
            end
            if (ab >= 0 && !sent && obs_code.size() == ab) begin
                lat = 20;
                if (txn.val) begin
                    vwait++;
                    if (vwait == 5) begin i_abort = 1'b1; sent = 1; end
                end
            end
            waited++;
        end
        i_start = 1'b0; i_abort = 1'b0;
        checks++;
        if (done_cnt == 0) begin
            errors++; $display("FAIL sweep_timeout: no o_done after %0d cycles, required done", waited);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({txn.val, txn.tune_code, o_busy, o_done, o_aborted, o_peak_code, o_peak_power,
             o_samp_val, o_samp_code, o_samp_power} !== 45'd0) begin
            errors++;
            $display("FAIL reset_outputs: val=%b code=%0d busy=%b done=%b ab=%b pk=%0d/%0d samp=%b %0d/%0d, required all 0",
                     txn.val, txn.tune_code, o_busy, o_done, o_aborted, o_peak_code, o_peak_power,
                     o_samp_val, o_samp_code, o_samp_power);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int d;
        run_sweep(10, 14, 1, 1, 0, -1, 0);
        checks++;
        if (first_val !== 1'b1 || first_code !== 8'd10) begin
            errors++; $display("FAIL basic_first_val: val=%b code=%0d, required val=1 code=10", first_val, first_code);
        end
        d = q_diff(obs_fire, exp_fire); checks++;
        if (d >= 0) begin errors++; $display("FAIL basic_fire_codes: got %0d fires, required %0d, first diff at %0d", obs_fire.size(), exp_fire.size(), d); end
        checks++;
        if (obs_code.size() != 5) begin errors++; $display("FAIL basic_samp_count: got %0d, required 5", obs_code.size()); end
        d = q_diff(obs_pow, exp_pow); checks++;
        if (d >= 0) begin errors++; $display("FAIL basic_samp_power: first diff at %0d", d); end
        checks++;
        if (o_peak_code !== 8'd12 || o_peak_power !== 8'd100) begin
            errors++; $display("FAIL basic_peak: got %0d/%0d, required 12/100", o_peak_code, o_peak_power);
        end
        checks++;
        if (done_cnt != 1 || done_abort !== 1'b0) begin
            errors++; $display("FAIL basic_done: count=%0d aborted=%b, required 1/0", done_cnt, done_abort);
        end
        checks++;
        if (done_cyc - last_samp_cyc != 1 || busy_after_done !== 1'b0) begin
            errors++; $display("FAIL basic_done_timing: gap=%0d busy_after=%b, required 1/0", done_cyc - last_samp_cyc, busy_after_done);
        end
        checks++;
        if (hold_err != 0) begin errors++; $display("FAIL basic_hold: %0d violations, required 0", hold_err); end
    endtask

    task automatic test_reset_mid();
        lat = 20; mode = 2;
        @(posedge clk); #1;
        i_code_start = 8'd30; i_code_end = 8'd40; i_code_step = 8'd1; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (txn.val !== 1'b1) begin errors++; $display("FAIL rstmid_val_before: val=%b, required 1", txn.val); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (txn.val !== 1'b0) begin errors++; $display("FAIL rstmid_val_drop: val=%b, required 0", txn.val); end
        @(negedge clk);
        checks++;
        if ({txn.val, txn.tune_code, o_busy, o_done, o_aborted, o_peak_code, o_peak_power,
             o_samp_val, o_samp_code, o_samp_power} !== 45'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: code=%0d busy=%b pk=%0d/%0d samp=%0d/%0d, required all 0",
                     txn.tune_code, o_busy, o_peak_code, o_peak_power, o_samp_code, o_samp_power);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Code-range corner cases: top-of-range overflow, zero step, reversed range.
    task automatic test_ranges();
        int d;
        run_sweep(250, 255, 4, 0, 2, -1, 0);
        d = q_diff(obs_code, exp_code); checks++;
        if (d >= 0 || obs_code.size() != 2 || done_cnt != 1) begin
            errors++; $display("FAIL overflow_codes: got %0d codes (first %0d), required 250,254", obs_code.size(), obs_code.size() ? obs_code[0] : 0);
        end
        run_sweep(5, 7, 0, 1, 2, -1, 0);
        d = q_diff(obs_fire, exp_fire); checks++;
        if (d >= 0 || obs_code.size() != 3) begin
            errors++; $display("FAIL step0_codes: got %0d codes, required 5,6,7", obs_code.size());
        end
        run_sweep(9, 3, 1, 2, 2, -1, 0);
        checks++;
        if (obs_code.size() != 1 || obs_code[0] !== 8'd9 || done_cnt != 1) begin
            errors++; $display("FAIL reversed_codes: got %0d codes, required single code 9", obs_code.size());
        end
    endtask

    task automatic test_ties();
        run_sweep(20, 30, 3, 1, 1, -1, 0);
        checks++;
        if (o_peak_code !== 8'd20 || o_peak_power !== 8'd50) begin
            errors++; $display("FAIL ties_peak: got %0d/%0d, required 20/50", o_peak_code, o_peak_power);
        end
    endtask

    task automatic test_abort();
        int d;
        run_sweep(0, 100, 1, 2, 2, 2, 0);
        d = q_diff(obs_code, exp_code); checks++;
        if (d >= 0) begin errors++; $display("FAIL abort_codes: got %0d codes, required %0d", obs_code.size(), exp_code.size()); end
        checks++;
        if (done_abort !== 1'b1 || o_aborted !== 1'b1) begin
            errors++; $display("FAIL abort_flag: at done=%b now=%b, required 1", done_abort, o_aborted);
        end
        checks++;
        if (hold_err != 0) begin errors++; $display("FAIL abort_hold: %0d violations, required 0", hold_err); end
        checks++;
        if (o_peak_code !== exp_pk_code || o_peak_power !== exp_pk_pow) begin
            errors++; $display("FAIL abort_peak: got %0d/%0d, required %0d/%0d", o_peak_code, o_peak_power, exp_pk_code, exp_pk_pow);
        end
    endtask

    task automatic test_busy_start();
        int d;
        run_sweep(40, 60, 5, 2, 2, -1, 1);
        d = q_diff(obs_fire, exp_fire); checks++;
        if (d >= 0 || done_cnt != 1) begin
            errors++; $display("FAIL busy_start_ignored: got %0d fires, required %0d", obs_fire.size(), exp_fire.size());
        end
    endtask

    task automatic test_random();
        int s, e, st, ab, d;
        for (int it = 0; it < 8; it++) begin
            s = $urandom_range(0, 255);
            e = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : s + $urandom_range(0, 20);
            if (e > 255) e = 255;
            st = $urandom_range(0, 5);
            ab = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(1, 3);
            run_sweep(s, e, st, $urandom_range(0, 3), 2, ab, 0);
            d = q_diff(obs_fire, exp_fire); checks++;
            if (d >= 0) begin errors++; $display("FAIL rand%0d_fires: s=%0d e=%0d st=%0d got %0d required %0d diff@%0d", it, s, e, st, obs_fire.size(), exp_fire.size(), d); end
            d = q_diff(obs_code, exp_code); checks++;
            if (d >= 0) begin errors++; $display("FAIL rand%0d_samp_code: got %0d required %0d diff@%0d", it, obs_code.size(), exp_code.size(), d); end
            d = q_diff(obs_pow, exp_pow); checks++;
            if (d >= 0) begin errors++; $display("FAIL rand%0d_samp_power: first diff at %0d", it, d); end
            checks++;
            if (o_peak_code !== exp_pk_code || o_peak_power !== exp_pk_pow) begin
                errors++; $display("FAIL rand%0d_peak: got %0d/%0d required %0d/%0d", it, o_peak_code, o_peak_power, exp_pk_code, exp_pk_pow);
            end
            checks++;
            if (done_cnt != 1 || done_abort !== exp_ab || done_cyc - last_samp_cyc != 1) begin
                errors++; $display("FAIL rand%0d_done: count=%0d ab=%b gap=%0d required 1/%b/1", it, done_cnt, done_abort, done_cyc - last_samp_cyc, exp_ab);
            end
        end
    endtask

`ifdef TUNER_SWEEP_AVG_EN
    task automatic test_avg();
        run_sweep(7, 7, 1, 1, 3, -1, 0);
        checks++;
        if (obs_fire.size() != 4 || obs_code.size() != 1) begin
            errors++; $display("FAIL avg_counts: fires=%0d samples=%0d, required 4/1", obs_fire.size(), obs_code.size());
        end
        checks++;
        if (obs_pow.size() == 0 || obs_pow[0] !== 8'd25) begin
            errors++; $display("FAIL avg_power: got %0d, required 25", obs_pow.size() ? obs_pow[0] : 0);
        end
    endtask
`endif

    initial begin
        clk = 1'b0; rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        i_code_start = '0; i_code_end = '0; i_code_step = '0;
        txn.rdy = 1'b0; txn.meas_power = '0;
        checks = 0; errors = 0; lat = 1; mode = 0; cyc = 0; fire_total = 0; waitc = 0;
        done_cnt = 0; done_cyc = 0; last_samp_cyc = 0; hold_err = 0;
        done_abort = 1'b0; busy_after_done = 1'b0;
        prev_val = 1'b0; prev_fire = 1'b0; prev_done = 1'b0; prev_code = '0;
        foreach (rtab[i]) rtab[i] = 8'($urandom_range(0, 255));
        test_reset();
        test_basic();
        test_reset_mid();
        test_ranges();
        test_ties();
        test_abort();
        test_busy_start();
        test_random();
`ifdef TUNER_SWEEP_AVG_EN
        test_avg();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
